mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-side stage of the SLC-3 datapath; owns MAR and MDR.
- Consumes the 16-bit shared bus (MAR/MDR loads) and runs a single-outstanding read or write transaction against synchronous-handshake memory.
- Read data lands in MDR, which the bus driver gates back onto the bus.
- A wait-state counter enforces a minimum access time; a timeout terminates hung accesses.

Parameters:
- MIN_WAIT, 1, minimum WAIT-state cycles before Mem_ready is honoured (>=1).
- TIMEOUT_CYCLES, 15, WAIT cycles without an honoured Mem_ready before the access aborts (> MIN_WAIT).

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Bus_in  in  16  shared datapath bus value.
- LD_MAR  in  1  load MAR from Bus_in.
- LD_MDR  in  1  load MDR from Bus_in.
- Rd_req  in  1  start a read at address MAR (sampled in IDLE only).
- Wr_req  in  1  start a write of MDR to address MAR (sampled in IDLE only).
- Mem_rdata  in  16  memory read data.
- Mem_ready  in  1  memory completion strobe.
- MAR  out  16  address register.
- MDR  out  16  data register.
- Mem_addr  out  16  equals MAR at all times.
- Mem_wdata  out  16  equals MDR at all times.
- Mem_CE  out  1  chip enable, high in SETUP and WAIT.
- Mem_OE  out  1  output enable, high in SETUP and WAIT of a read.
- Mem_WE  out  1  write enable, high in SETUP and WAIT of a write.
- Busy  out  1  high in SETUP, WAIT and DONE.
- Done  out  1  one-cycle pulse in DONE.
- Err  out  1  last access timed out; sticky until the next accepted request or Reset.

Behaviour:
- Reset (any state, including mid-access) produces:
  - state IDLE, MAR=0, MDR=0, counter=0, op=read.
  - Mem_CE/OE/WE=0, Busy=0, Done=0, Err=0.
- FSM states: IDLE, SETUP, WAIT, DONE. All outputs are registered-state decodes; no combinational path from inputs to strobes.
- IDLE:
  - Rd_req=1 → SETUP with op=read. Rd_req has priority when both requests are high; Wr_req is dropped.
  - Wr_req=1 (Rd_req=0) → SETUP with op=write.
  - Accepting a request clears Err.
- SETUP: exactly 1 cycle → WAIT; counter cleared to 0.
- WAIT: each cycle, let n = counter+1.
  - Mem_ready=1 and n>=MIN_WAIT → DONE. For a read, MDR<=Mem_rdata on this same edge.
  - Otherwise, n==TIMEOUT_CYCLES → DONE with Err<=1; MDR unchanged.
  - Otherwise counter<=n.
  - Mem_ready is ignored while n<MIN_WAIT; the memory must hold or re-assert it.
- DONE: Done=1 for 1 cycle → IDLE. Requests presented in DONE are ignored, not queued.
- Counter width: clog2(TIMEOUT_CYCLES+1); it never wraps.
- Fastest read latency (MIN_WAIT=1, Mem_ready high):
  - Request sampled at edge E0; SETUP during cycle 1; WAIT during cycle 2.
  - MDR updated at E2; Done high in cycle 3; IDLE in cycle 4.
  - Four cycles from request to IDLE.
- MAR/MDR loads:
  - LD_MAR in IDLE: MAR<=Bus_in. LD_MDR in IDLE: MDR<=Bus_in. Both may load on the same edge.
  - While Busy, LD_MAR and LD_MDR are ignored, so address and write data stay stable for the whole access.
  - LD_MAR/LD_MDR and Rd_req/Wr_req together in IDLE: the register loads and the request is accepted on the same edge. The access uses the newly loaded value, because Mem_addr and Mem_wdata follow the register from SETUP onward.
- Write access: MDR is never modified by the transaction.

Test Plan:
- Reset mid-WAIT of a read (MAR=0x3000): assert Reset for 1 cycle → next cycle state IDLE, MAR=0, MDR=0, all strobes 0, Err=0.
- Load then read: Bus_in=0x3000 with LD_MAR; Rd_req; Mem_ready=1 from the first WAIT cycle with Mem_rdata=0xBEEF → Mem_addr=0x3000, Mem_OE high 2 cycles, MDR=0xBEEF after E2, Done pulse in cycle 3, Busy 3 cycles.
- Write with MIN_WAIT=3: MAR=0x1234, MDR=0x00FF, Wr_req, Mem_ready held high → Mem_WE high for SETUP plus 3 WAIT cycles, Done after; MDR stays 0x00FF; Mem_OE never high.
- Timeout: Rd_req, Mem_ready held 0, TIMEOUT_CYCLES=15 → DONE after 15 WAIT cycles, Err=1, MDR unchanged. The next Rd_req clears Err on acceptance.
- Simultaneous Rd_req and Wr_req in IDLE → read performed (Mem_OE=1, Mem_WE=0), no write follows.
- Ignored while busy: during WAIT assert LD_MAR with Bus_in=0xFFFF, LD_MDR, and Rd_req → MAR, MDR and Mem_addr unchanged; a single Done pulse; no second transaction.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Datapath and memory-side signals of the SLC-3 memory access stage.
// The datapath/test side holds the master modport; the access unit holds the slave modport.
interface mem_access_unit_if;
  logic [15:0] Bus_in;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        Rd_req;
  logic        Wr_req;
  logic [15:0] Mem_rdata;
  logic        Mem_ready;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Mem_addr;
  logic [15:0] Mem_wdata;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Busy;
  logic        Done;
  logic        Err;

  modport master (
    output Bus_in, LD_MAR, LD_MDR, Rd_req, Wr_req, Mem_rdata, Mem_ready,
    input  MAR, MDR, Mem_addr, Mem_wdata, Mem_CE, Mem_OE, Mem_WE, Busy, Done, Err
  );

  modport slave (
    input  Bus_in, LD_MAR, LD_MDR, Rd_req, Wr_req, Mem_rdata, Mem_ready,
    output MAR, MDR, Mem_addr, Mem_wdata, Mem_CE, Mem_OE, Mem_WE, Busy, Done, Err
  );
endinterface

// File: rtl/mem_access_unit.sv
// SLC-3 memory access stage: owns MAR/MDR and runs one read or write at a time
// against a handshake memory, with a minimum wait and a hung-access timeout.
module mem_access_unit #(
  parameter int MIN_WAIT       = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic             Clk,
  input logic             Reset,
  mem_access_unit_if.slave mau
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MIN_N = CW'(MIN_WAIT);
  localparam logic [CW-1:0] TO_N  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

  state_t        state;
  logic [15:0]   mar, mdr;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic          ce, oe, we, busy, done, err;
  logic [CW-1:0] n;

  // n is the number of WAIT cycles completed including the current one
  assign n = cnt + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      cnt   <= '0;
      op_wr <= 1'b0;
      ce    <= 1'b0;
      oe    <= 1'b0;
      we    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mau.LD_MAR) mar <= mau.Bus_in;
          if (mau.LD_MDR) mdr <= mau.Bus_in;
          // Read wins a tie; the write request is simply dropped
          if (mau.Rd_req || mau.Wr_req) begin
            state <= SETUP;
            op_wr <= ~mau.Rd_req;
            err   <= 1'b0;
            ce    <= 1'b1;
            oe    <= mau.Rd_req;
            we    <= ~mau.Rd_req;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (mau.Mem_ready && (n >= MIN_N)) begin
            state <= DONE;
            if (!op_wr) mdr <= mau.Mem_rdata;
            ce   <= 1'b0;
            oe   <= 1'b0;
            we   <= 1'b0;
            done <= 1'b1;
          end else if (n == TO_N) begin
            state <= DONE;
            err   <= 1'b1;
            ce    <= 1'b0;
            oe    <= 1'b0;
            we    <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= n;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mau.MAR       = mar;
  assign mau.MDR       = mdr;
  assign mau.Mem_addr  = mar;
  assign mau.Mem_wdata = mdr;
  assign mau.Mem_CE    = ce;
  assign mau.Mem_OE    = oe;
  assign mau.Mem_WE    = we;
  assign mau.Busy      = busy;
  assign mau.Done      = done;
  assign mau.Err       = err;
endmodule
